// File: rtl/can_tx_prio_queue.sv
// CAN transmit priority buffer: holds up to DEPTH frames, presents the lowest-ID
// (oldest among equal IDs) frame to the bit engine, retries on arbitration loss.
module can_tx_prio_queue #(
  parameter int DEPTH     = 8,
  parameter int ID_W      = 11,
  parameter int MAX_RETRY = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ID_W-1:0]          req_id,
  input  logic [3:0]               req_dlc,
  input  logic [7:0]               req_data [8],
  input  logic                     flush,
  output logic                     tx_valid,
  output logic [ID_W-1:0]          tx_id,
  output logic [3:0]               tx_dlc,
  output logic [7:0]               tx_data [8],
  input  logic                     tx_done,
  input  logic                     tx_arb_lost,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [ID_W-1:0]          drop_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    MAX_R8  = 8'(MAX_RETRY);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ID_W-1:0]   id_q    [DEPTH];
  logic [3:0]        dlc_q   [DEPTH];
  logic [7:0]        data_q  [DEPTH][8];
  logic [AW-1:0]     age_q   [DEPTH];
  logic [AW-1:0]     age_d   [DEPTH];
  logic [7:0]        retry_q [DEPTH];
  logic [7:0]        retry_d [DEPTH];
  logic [AW-1:0]     cur_q, cur_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ID_W-1:0]   tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [7:0]        tx_data_q [8];
  logic [7:0]        tx_data_d [8];
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              drop_q, drop_d;
  logic [ID_W-1:0]   drop_id_q, drop_id_d;

  logic              sel_found_s;
  logic [AW-1:0]     sel_idx_s;
  logic [ID_W-1:0]   sel_id_s;
  logic [AW-1:0]     sel_age_s;
  logic              free_found_s;
  logic [AW-1:0]     free_idx_s;
  logic              accept_s;
  logic              clr_s;
  logic              dec_s;
  logic [7:0]        retry_inc_s;

  assign req_ready   = !full_q && !flush;
  assign accept_s    = req_valid && req_ready;
  assign retry_inc_s = retry_q[cur_q] + 8'd1;

  // Priority pick: lowest id, then largest age (oldest) among equal ids.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_id_s    = '0;
    sel_age_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (!sel_found_s || (id_q[i] < sel_id_s) ||
                       ((id_q[i] == sel_id_s) && (age_q[i] > sel_age_s)))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = AW'(i);
        sel_id_s    = id_q[i];
        sel_age_s   = age_q[i];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld_q[i] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = AW'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    age_d      = age_q;
    retry_d    = retry_q;
    cur_d      = cur_q;
    tx_valid_d = tx_valid_q;
    tx_id_d    = tx_id_q;
    tx_dlc_d   = tx_dlc_q;
    tx_data_d  = tx_data_q;
    drop_d     = 1'b0;
    drop_id_d  = drop_id_q;
    count_d    = count_q;
    clr_s      = 1'b0;
    dec_s      = 1'b0;

    if (flush) begin
      state_d    = ST_IDLE;
      vld_d      = '0;
      tx_valid_d = 1'b0;
      count_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found_s) begin
            cur_d      = sel_idx_s;
            tx_id_d    = id_q[sel_idx_s];
            tx_dlc_d   = dlc_q[sel_idx_s];
            tx_data_d  = data_q[sel_idx_s];
            tx_valid_d = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (tx_done) begin
            clr_s      = 1'b1;
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (tx_arb_lost) begin
            retry_d[cur_q] = retry_inc_s;
            tx_valid_d     = 1'b0;
            state_d        = ST_IDLE;
            if (retry_inc_s == MAX_R8) begin
              clr_s     = 1'b1;
              drop_d    = 1'b1;
              drop_id_d = tx_id_q;
            end else begin
              clr_s = 1'b0;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      endcase

      // Ages are kept as a dense rank (0 = newest): a clear closes the gap it leaves,
      // so ages stay distinct and below DEPTH however the queue drains.
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && !(clr_s && (cur_q == AW'(i)))) begin
          dec_s    = clr_s && (age_q[i] > age_q[cur_q]);
          age_d[i] = age_q[i] + AW'(accept_s) - AW'(dec_s);
        end else begin
          age_d[i] = age_q[i];
        end
      end

      if (clr_s) begin
        vld_d[cur_q] = 1'b0;
      end else begin
        vld_d[cur_q] = vld_d[cur_q];
      end

      if (accept_s) begin
        vld_d[free_idx_s]   = 1'b1;
        age_d[free_idx_s]   = '0;
        retry_d[free_idx_s] = 8'd0;
      end else begin
        vld_d[free_idx_s] = vld_d[free_idx_s];
      end

      count_d = count_q + CW'(accept_s) - CW'(clr_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vld_q      <= '0;
      cur_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_id_q    <= '0;
      tx_dlc_q   <= 4'd0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      drop_q     <= 1'b0;
      drop_id_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]   <= '0;
        retry_q[i] <= 8'd0;
      end
      for (int b = 0; b < 8; b++) begin
        tx_data_q[b] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      cur_q      <= cur_d;
      tx_valid_q <= tx_valid_d;
      tx_id_q    <= tx_id_d;
      tx_dlc_q   <= tx_dlc_d;
      tx_data_q  <= tx_data_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      drop_q     <= drop_d;
      drop_id_q  <= drop_id_d;
      age_q      <= age_d;
      retry_q    <= retry_d;
    end
  end

  // Payload storage needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      id_q[free_idx_s]   <= req_id;
      dlc_q[free_idx_s]  <= req_dlc;
      data_q[free_idx_s] <= req_data;
    end else begin
      id_q[free_idx_s] <= id_q[free_idx_s];
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_id    = tx_id_q;
  assign tx_dlc   = tx_dlc_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign drop     = drop_q;
  assign drop_id  = drop_id_q;

endmodule
